// File: rtl/cache_req_driver_pkg.sv
// Shared types and constants for the cache request driver and its benches.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } drvState_t;

  localparam int WRITE_AROUND  = 0;
  localparam int WRITE_THROUGH = 1;
  localparam int WRITE_BACK    = 2;

  // Width of a counter that must reach maxVal inclusive; never narrower than 1 bit.
  function automatic int ctrWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/cache_req_driver_if.sv
// Request/response port plus the cache up-port signals driven by cache_req_driver.
interface cache_req_driver_if #(
  parameter int ADDR_LENGTH = 11,
  parameter int DATA_WIDTH  = 32,
  parameter int LAT_W       = 8
);
  logic                   reqValid;
  logic                   reqReady;
  logic [ADDR_LENGTH-1:0] reqAddr;
  logic                   reqWrite;
  logic [DATA_WIDTH-1:0]  reqData;

  logic                   rspValid;
  logic [DATA_WIDTH-1:0]  rspData;
  logic                   rspWrite;
  logic                   rspTimeout;
  logic [LAT_W-1:0]       rspLatency;

  logic [ADDR_LENGTH-1:0] addrOut;
  logic [DATA_WIDTH-1:0]  dataOut;
  logic                   enableOut;
  logic                   writeOut;
  logic [DATA_WIDTH-1:0]  dataIn;
  logic                   fetchComplete;
  logic                   writeComplete;
  logic                   busy;

  modport master (
    input  reqValid, reqAddr, reqWrite, reqData, dataIn, fetchComplete, writeComplete,
    output reqReady, rspValid, rspData, rspWrite, rspTimeout, rspLatency,
           addrOut, dataOut, enableOut, writeOut, busy
  );

  modport slave (
    output reqValid, reqAddr, reqWrite, reqData, dataIn, fetchComplete, writeComplete,
    input  reqReady, rspValid, rspData, rspWrite, rspTimeout, rspLatency,
           addrOut, dataOut, enableOut, writeOut, busy
  );
endinterface

// File: rtl/cache_req_driver_fifo.sv
// Small request FIFO: registered count drives full/empty, head is read combinationally.
module req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pushValid,
  input  logic [WIDTH-1:0] pushData,
  input  logic             popEn,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtrReg;
  logic [PTR_W-1:0] rdPtrReg;
  logic [CNT_W-1:0] countReg;
  logic             doPush;
  logic             doPop;

  assign full    = (countReg == CNT_W'(DEPTH));
  assign empty   = (countReg == '0);
  assign count   = countReg;
  assign doPush  = pushValid && !full;
  assign doPop   = popEn && !empty;
  assign popData = mem[rdPtrReg];

  // Storage is left unreset so it maps onto plain distributed RAM.
  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtrReg] <= pushData;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (doPush) wrPtrReg <= wrPtrReg + PTR_W'(1);
      if (doPop)  rdPtrReg <= rdPtrReg + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   countReg <= countReg + CNT_W'(1);
        2'b01:   countReg <= countReg - CNT_W'(1);
        default: countReg <= countReg;
      endcase
    end
  end
endmodule

// File: rtl/cache_req_driver.sv
// Queues requests and issues them one at a time to the cache using its level-held
// enable protocol, returning a one-cycle response pulse with data, latency and timeout.
module cache_req_driver
  import cache_pkg::*;
#(
  parameter int ADDR_LENGTH = 11,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 255,
  parameter int IDLE_GAP    = 2,
  localparam int LAT_W = $clog2(TIMEOUT + 1)
) (
  input logic                clock,
  input logic                reset,
  cache_req_driver_if.master bus
);
  localparam int ENTRY_W = ADDR_LENGTH + DATA_WIDTH + 1;
  localparam int GAP_W   = ctrWidth(IDLE_GAP);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

  drvState_t              stateReg, stateNext;
  logic [ENTRY_W-1:0]     headEntry;
  logic                   headWrite;
  logic [ADDR_LENGTH-1:0] headAddr;
  logic [DATA_WIDTH-1:0]  headData;
  logic                   fifoFull, fifoEmpty;
  logic [CNT_W-1:0]       fifoCount;
  logic                   doPop, doFinish, doAbort, done;

  logic [ADDR_LENGTH-1:0] addrReg;
  logic [DATA_WIDTH-1:0]  dataReg;
  logic                   enableReg, writeReg;
  logic [LAT_W-1:0]       cntReg;
  logic [GAP_W-1:0]       gapCntReg;
  logic                   rspValidReg, rspWriteReg, rspTimeoutReg;
  logic [DATA_WIDTH-1:0]  rspDataReg;
  logic [LAT_W-1:0]       rspLatencyReg;

  req_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) reqQueue (
    .clock    (clock),
    .reset    (reset),
    .pushValid(bus.reqValid),
    .pushData ({bus.reqWrite, bus.reqAddr, bus.reqData}),
    .popEn    (doPop),
    .popData  (headEntry),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  assign {headWrite, headAddr, headData} = headEntry;
  assign done = bus.fetchComplete | bus.writeComplete;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stateReg <= IDLE;
    else       stateReg <= stateNext;
  end

  // A completion on the last allowed cycle wins over the timeout abort.
  always_comb begin
    stateNext = stateReg;
    doPop     = 1'b0;
    doFinish  = 1'b0;
    doAbort   = 1'b0;
    unique case (stateReg)
      IDLE: if (!fifoEmpty) begin
        doPop     = 1'b1;
        stateNext = ISSUE;
      end
      ISSUE: if (done) begin
        doFinish  = 1'b1;
        stateNext = GAP;
      end else if (cntReg == LAT_W'(TIMEOUT - 1)) begin
        doAbort   = 1'b1;
        stateNext = GAP;
      end
      GAP: if (gapCntReg == GAP_W'(IDLE_GAP - 1)) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addrReg       <= '0;
      dataReg       <= '0;
      enableReg     <= 1'b0;
      writeReg      <= 1'b0;
      cntReg        <= '0;
      gapCntReg     <= '0;
      rspValidReg   <= 1'b0;
      rspWriteReg   <= 1'b0;
      rspTimeoutReg <= 1'b0;
      rspDataReg    <= '0;
      rspLatencyReg <= '0;
    end else begin
      rspValidReg <= 1'b0;
      gapCntReg   <= (stateReg == GAP) ? gapCntReg + GAP_W'(1) : '0;
      if (doPop) begin
        addrReg   <= headAddr;
        dataReg   <= headData;
        writeReg  <= headWrite;
        enableReg <= 1'b1;
        cntReg    <= '0;
      end else if (doFinish) begin
        rspValidReg   <= 1'b1;
        rspDataReg    <= writeReg ? '0 : bus.dataIn;
        rspLatencyReg <= cntReg + LAT_W'(1);
        rspTimeoutReg <= 1'b0;
        rspWriteReg   <= writeReg;
        enableReg     <= 1'b0;
        writeReg      <= 1'b0;
      end else if (doAbort) begin
        rspValidReg   <= 1'b1;
        rspDataReg    <= '0;
        rspLatencyReg <= LAT_W'(TIMEOUT);
        rspTimeoutReg <= 1'b1;
        rspWriteReg   <= writeReg;
        enableReg     <= 1'b0;
        writeReg      <= 1'b0;
      end else if (stateReg == ISSUE && cntReg != LAT_W'(TIMEOUT)) begin
        cntReg <= cntReg + LAT_W'(1);
      end
    end
  end

  assign bus.reqReady   = !fifoFull;
  assign bus.busy       = (stateReg != IDLE) || (fifoCount != '0);
  assign bus.addrOut    = addrReg;
  assign bus.dataOut    = dataReg;
  assign bus.enableOut  = enableReg;
  assign bus.writeOut   = writeReg;
  assign bus.rspValid   = rspValidReg;
  assign bus.rspData    = rspDataReg;
  assign bus.rspWrite   = rspWriteReg;
  assign bus.rspTimeout = rspTimeoutReg;
  assign bus.rspLatency = rspLatencyReg;
endmodule
